// File: rtl/axi4_lite_write_router.sv
// AXI4-Lite write-channel router: captures one AW, asks the address decoder for a
// target, steers AW/W to that slave and returns its B response (or a local DECERR).
module axi4_lite_write_router #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SLAVE_NUM  = 2,
    localparam int STRB_W    = DATA_WIDTH / 8,
    localparam int IDX_W     = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  s_awaddr,
    input  logic                   s_awvalid,
    output logic                   s_awready,
    input  logic [DATA_WIDTH-1:0]  s_wdata,
    input  logic [STRB_W-1:0]      s_wstrb,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    output logic [1:0]             s_bresp,
    output logic                   s_bvalid,
    input  logic                   s_bready,
    output logic [ADDR_WIDTH-1:0]  dec_addr,
    input  logic [SLAVE_NUM-1:0]   dec_slave_sel,
    input  logic [IDX_W-1:0]       dec_sel_idx,
    output logic [ADDR_WIDTH-1:0]  m_awaddr,
    output logic [SLAVE_NUM-1:0]   m_awvalid,
    input  logic [SLAVE_NUM-1:0]   m_awready,
    output logic [DATA_WIDTH-1:0]  m_wdata,
    output logic [STRB_W-1:0]      m_wstrb,
    output logic [SLAVE_NUM-1:0]   m_wvalid,
    input  logic [SLAVE_NUM-1:0]   m_wready,
    input  logic [2*SLAVE_NUM-1:0] m_bresp,
    input  logic [SLAVE_NUM-1:0]   m_bvalid,
    output logic [SLAVE_NUM-1:0]   m_bready
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // valid never waits on ready, and a raised valid holds with stable payload until then.
    typedef enum logic [2:0] {IDLE, DECODE, FWD, ERR_W, RESP, ERR_RESP} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [IDX_W-1:0]        tgt_idx_q;
    logic                    aw_done;
    logic                    w_done;

    logic [SLAVE_NUM-1:0]    tgt_oh;
    logic [1:0]              tgt_bresp;
    logic                    tgt_awready;
    logic                    tgt_wready;
    logic                    tgt_bvalid;
    logic                    aw_hs;
    logic                    w_hs;

    always_comb begin
        tgt_oh    = '0;
        tgt_bresp = 2'b00;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (tgt_idx_q == IDX_W'(i)) begin
                tgt_oh[i] = 1'b1;
                tgt_bresp = m_bresp[2*i +: 2];
            end
        end
    end

    assign tgt_awready = |(m_awready & tgt_oh);
    assign tgt_wready  = |(m_wready & tgt_oh);
    assign tgt_bvalid  = |(m_bvalid & tgt_oh);
    assign aw_hs       = (state == FWD) && !aw_done && tgt_awready;
    assign w_hs        = (state == FWD) && !w_done && s_wvalid && tgt_wready;

    assign dec_addr  = aw_addr_q;
    assign m_awaddr  = aw_addr_q;
    assign m_wdata   = s_wdata;
    assign m_wstrb   = s_wstrb;
    assign s_awready = (state == IDLE);
    assign s_wready  = ((state == FWD) && tgt_wready && !w_done) || (state == ERR_W);
    assign m_awvalid = ((state == FWD) && !aw_done) ? tgt_oh : '0;
    assign m_wvalid  = ((state == FWD) && !w_done && s_wvalid) ? tgt_oh : '0;
    assign m_bready  = ((state == RESP) && s_bready) ? tgt_oh : '0;
    assign s_bvalid  = ((state == RESP) && tgt_bvalid) || (state == ERR_RESP);
    assign s_bresp   = (state == RESP)     ? tgt_bresp :
                       (state == ERR_RESP) ? 2'b11     : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            aw_addr_q <= '0;
            tgt_idx_q <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_awvalid) begin
                        aw_addr_q <= s_awaddr;
                        state     <= DECODE;
                    end
                end
                DECODE: begin
                    if (|dec_slave_sel) begin
                        tgt_idx_q <= dec_sel_idx;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        state     <= FWD;
                    end else begin
                        state <= ERR_W;
                    end
                end
                FWD: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    // Leave as soon as the later of the two channels completes.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) state <= RESP;
                end
                ERR_W: begin
                    if (s_wvalid) state <= ERR_RESP;
                end
                RESP: begin
                    if (s_bready && tgt_bvalid) state <= IDLE;
                end
                ERR_RESP: begin
                    if (s_bready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_write_router.sv
// Directed bench for axi4_lite_write_router: table of single-transaction vectors
// plus hand-written sequences for stalls, B backpressure and mid-transaction reset.
module tb_axi4_lite_write_router;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] dec_addr;
    logic [1:0]  dec_slave_sel;
    logic [0:0]  dec_sel_idx;
    logic [31:0] m_awaddr;
    logic [1:0]  m_awvalid;
    logic [1:0]  m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_wvalid;
    logic [1:0]  m_wready;
    logic [3:0]  m_bresp;
    logic [1:0]  m_bvalid;
    logic [1:0]  m_bready;

    int n_chk;
    int n_fail;

    axi4_lite_write_router #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLAVE_NUM(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .dec_addr(dec_addr), .dec_slave_sel(dec_slave_sel), .dec_sel_idx(dec_sel_idx),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder model: 0x0xxx_xxxx -> slave 0, 0x1xxx_xxxx -> slave 1,
    // 0x3xxx_xxxx -> both hit with index 1, anything else unmapped.
    always_comb begin
        dec_slave_sel = 2'b00;
        dec_sel_idx   = 1'b0;
        case (dec_addr[31:28])
            4'h0: begin dec_slave_sel = 2'b01; dec_sel_idx = 1'b0; end
            4'h1: begin dec_slave_sel = 2'b10; dec_sel_idx = 1'b1; end
            4'h3: begin dec_slave_sel = 2'b11; dec_sel_idx = 1'b1; end
            default: begin dec_slave_sel = 2'b00; dec_sel_idx = 1'b0; end
        endcase
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  slv_bresp;
        logic [1:0]  exp_oh;
        logic [1:0]  exp_bresp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [31:0] addr);
        s_awaddr  = addr;
        s_awvalid = 1'b1;
        @(negedge clk);
        chk("idle_awready", s_awready, 1'b1);
        tick();
        s_awvalid = 1'b0;
    endtask

    // Runs cycles T+1..T+4 of a transaction whose AW was just accepted, with ready slaves.
    task automatic do_rest(input vec_t v);
        s_wvalid = 1'b1;
        s_wdata  = v.data;
        s_wstrb  = v.strb;
        m_bresp  = v.slv_bresp;
        @(negedge clk);
        chk("decode_dec_addr", dec_addr, v.addr);
        chk("decode_m_awaddr", m_awaddr, v.addr);
        chk("decode_m_awvalid", m_awvalid, 2'b00);
        chk("decode_s_wready", s_wready, 1'b0);
        chk("decode_s_awready", s_awready, 1'b0);
        tick();
        @(negedge clk);
        chk("fwd_m_awvalid", m_awvalid, v.exp_oh);
        chk("fwd_m_wvalid", m_wvalid, v.exp_oh);
        chk("fwd_m_wdata", m_wdata, v.data);
        chk("fwd_m_wstrb", m_wstrb, v.strb);
        chk("fwd_s_wready", s_wready, 1'b1);
        chk("fwd_s_bvalid", s_bvalid, 1'b0);
        tick();
        s_wvalid = 1'b0;
        s_bready = 1'b1;
        @(negedge clk);
        chk("resp_s_bvalid", s_bvalid, 1'b1);
        chk("resp_s_bresp", s_bresp, v.exp_bresp);
        chk("resp_m_bready", m_bready, v.exp_oh);
        chk("resp_m_awvalid", m_awvalid, 2'b00);
        chk("resp_m_wvalid", m_wvalid, 2'b00);
        tick();
        s_bready = 1'b0;
        @(negedge clk);
        chk("after_b_awready", s_awready, 1'b1);
        chk("after_b_bvalid", s_bvalid, 1'b0);
    endtask

    initial begin
        vec_t v;
        n_chk = 0;
        n_fail = 0;
        //            addr           data           strb  {b1,b0}   oh     bresp
        vecs[0] = '{32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 4'b0010, 2'b10, 2'b00};
        vecs[1] = '{32'h0000_0010, 32'h1234_5678, 4'h3, 4'b1100, 2'b01, 2'b00};
        vecs[2] = '{32'h1000_0100, 32'h0000_A5A5, 4'h8, 4'b1000, 2'b10, 2'b10};
        vecs[3] = '{32'h2000_0000, 32'h5555_AAAA, 4'hF, 4'b0101, 2'b00, 2'b11};
        vecs[4] = '{32'h0000_0FFC, 32'h0BAD_F00D, 4'h1, 4'b0001, 2'b01, 2'b01};
        vecs[5] = '{32'hF000_0000, 32'h8765_4321, 4'hC, 4'b0000, 2'b00, 2'b11};
        vecs[6] = '{32'h3000_0000, 32'hFACE_0001, 4'h6, 4'b0110, 2'b10, 2'b01};

        rst_n     = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        m_awready = 2'b11;
        m_wready  = 2'b11;
        m_bvalid  = 2'b11;
        m_bresp   = 4'b0000;

        #12;
        chk("rst_m_awvalid", m_awvalid, 2'b00);
        chk("rst_m_wvalid", m_wvalid, 2'b00);
        chk("rst_m_bready", m_bready, 2'b00);
        chk("rst_s_wready", s_wready, 1'b0);
        chk("rst_s_bvalid", s_bvalid, 1'b0);
        chk("rst_s_bresp", s_bresp, 2'b00);
        chk("rst_dec_addr", dec_addr, 32'h0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_aw(vecs[i].addr);
            do_rest(vecs[i]);
            tick();
        end

        // AW stalled three cycles while W completes first.
        m_awready = 2'b00;
        m_bresp   = 4'b0000;
        do_aw(32'h1000_0008);
        s_wvalid = 1'b1;
        s_wdata  = 32'hCAFE_F00D;
        s_wstrb  = 4'hF;
        tick();
        @(negedge clk);
        chk("stall_m_awvalid", m_awvalid, 2'b10);
        chk("stall_m_wvalid", m_wvalid, 2'b10);
        chk("stall_s_wready", s_wready, 1'b1);
        tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_hold_awvalid", m_awvalid, 2'b10);
            chk("stall_w_done_wvalid", m_wvalid, 2'b00);
            chk("stall_w_done_wready", s_wready, 1'b0);
            chk("stall_no_bvalid", s_bvalid, 1'b0);
            tick();
        end
        m_awready = 2'b11;
        @(negedge clk);
        chk("stall_release_awvalid", m_awvalid, 2'b10);
        tick();
        s_wvalid = 1'b0;
        s_bready = 1'b1;
        @(negedge clk);
        chk("stall_s_bvalid", s_bvalid, 1'b1);
        chk("stall_s_bresp", s_bresp, 2'b00);
        chk("stall_m_awvalid_done", m_awvalid, 2'b00);
        tick();
        s_bready = 1'b0;
        @(negedge clk);
        chk("stall_single_b", s_bvalid, 1'b0);
        chk("stall_idle_awready", s_awready, 1'b1);
        tick();

        // B backpressure for four cycles with the next AW already waiting.
        m_bresp = 4'b0000;
        do_aw(32'h0000_0020);
        s_wvalid = 1'b1;
        s_wdata  = 32'h0101_0101;
        s_wstrb  = 4'hF;
        tick();
        tick();
        s_wvalid  = 1'b0;
        s_awvalid = 1'b1;
        s_awaddr  = 32'h1000_0040;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_s_bvalid", s_bvalid, 1'b1);
            chk("bp_m_bready", m_bready, 2'b00);
            chk("bp_s_awready", s_awready, 1'b0);
            tick();
        end
        s_bready = 1'b1;
        @(negedge clk);
        chk("bp_hs_bvalid", s_bvalid, 1'b1);
        chk("bp_hs_m_bready", m_bready, 2'b01);
        tick();
        s_bready = 1'b0;
        @(negedge clk);
        chk("bp_next_awready", s_awready, 1'b1);
        tick();
        s_awvalid = 1'b0;
        v = '{32'h1000_0040, 32'h7777_0000, 4'hA, 4'b1000, 2'b10, 2'b10};
        do_rest(v);
        tick();

        // Reset asserted in FWD while m_awvalid is high.
        m_awready = 2'b00;
        m_wready  = 2'b00;
        do_aw(32'h1000_000C);
        s_wvalid = 1'b1;
        s_wdata  = 32'h9999_9999;
        tick();
        @(negedge clk);
        chk("prerst_m_awvalid", m_awvalid, 2'b10);
        chk("prerst_m_wvalid", m_wvalid, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_awvalid", m_awvalid, 2'b00);
        chk("midrst_m_wvalid", m_wvalid, 2'b00);
        chk("midrst_s_wready", s_wready, 1'b0);
        chk("midrst_s_bvalid", s_bvalid, 1'b0);
        chk("midrst_idle_awready", s_awready, 1'b1);
        tick();
        rst_n     = 1'b1;
        s_wvalid  = 1'b0;
        m_awready = 2'b11;
        m_wready  = 2'b11;
        do_aw(vecs[0].addr);
        do_rest(vecs[0]);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_write_router.md
# axi4_lite_write_router

Write-channel router for the AXI4-Lite interconnect, directly downstream of the address decoder. It accepts one write transaction at a time from a single master and captures the AW address. It presents the captured address to the decoder, registers the one-hot/index result, and steers AW/W to the selected slave. It returns that slave's B response, or generates DECERR locally when no slave decodes.

## Interface
- ADDR_WIDTH, 32, address width; also the width of dec_addr.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- SLAVE_NUM, 2, number of slave ports; index width is $clog2(SLAVE_NUM).
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_awaddr  in  ADDR_WIDTH  master write address.
- s_awvalid / s_awready  in / out  1  master AW handshake.
- s_wdata  in  DATA_WIDTH  master write data.
- s_wstrb  in  DATA_WIDTH/8  master write strobes.
- s_wvalid / s_wready  in / out  1  master W handshake.
- s_bresp  out  2  write response to master.
- s_bvalid / s_bready  out / in  1  master B handshake.
- dec_addr  out  ADDR_WIDTH  registered AW address driven to the decoder.
- dec_slave_sel  in  SLAVE_NUM  one-hot hit vector from the decoder.
- dec_sel_idx  in  $clog2(SLAVE_NUM)  hit index from the decoder.
- m_awaddr  out  ADDR_WIDTH  address broadcast to all slaves.
- m_awvalid / m_awready  out / in  SLAVE_NUM  per-slave AW handshake.
- m_wdata  out  DATA_WIDTH  data broadcast to all slaves.
- m_wstrb  out  DATA_WIDTH/8  strobes broadcast to all slaves.
- m_wvalid / m_wready  out / in  SLAVE_NUM  per-slave W handshake.
- m_bresp  in  2*SLAVE_NUM  per-slave response; slave i occupies bits [2i+1:2i].
- m_bvalid / m_bready  in / out  SLAVE_NUM  per-slave B handshake.

## Operation
- States: IDLE, DECODE, FWD, ERR_W, RESP, ERR_RESP. Reset state is IDLE.
- Registers cleared on reset: aw_addr_q, tgt_idx_q, aw_done, w_done.
- Outputs during reset: all m_*valid, m_bready, s_wready and s_bvalid are 0; s_bresp=2'b00.
- IDLE: s_awready=1.
  - On s_awvalid&s_awready: aw_addr_q<=s_awaddr, then go to DECODE.
  - W is never accepted in IDLE; s_wready=0.
- dec_addr = aw_addr_q at all times. m_awaddr = aw_addr_q.
- DECODE lasts one cycle:
  - hit = |dec_slave_sel.
  - If hit: tgt_idx_q<=dec_sel_idx, clear aw_done and w_done, go to FWD.
  - Else: go to ERR_W.
- FWD:
  - m_awvalid[tgt]=!aw_done; set aw_done on m_awready[tgt].
  - m_wvalid[tgt]=s_wvalid&!w_done; s_wready=m_wready[tgt]&!w_done.
  - m_wdata=s_wdata, m_wstrb=s_wstrb (combinational pass-through). Set w_done on the W handshake.
  - AW and W complete independently, in either order or the same cycle.
  - Go to RESP in the cycle after both done flags are set, or directly when the last handshake occurs.
- Non-target slaves always see valid=0 and bready=0.
- ERR_W: s_wready=1. Consume one W beat and discard it, then go to ERR_RESP.
- RESP:
  - s_bvalid=m_bvalid[tgt], s_bresp=m_bresp[tgt], m_bready[tgt]=s_bready.
  - On handshake, go to IDLE.
  - Stray m_bvalid from other slaves is ignored.
- ERR_RESP: s_bvalid=1, s_bresp=2'b11 (DECERR). On s_bready, go to IDLE.
- Only one outstanding transaction. s_awready=0 in every state except IDLE.
- Multiple decoder hits: dec_sel_idx is used as-is; the router does not re-arbitrate.
- Reset mid-transaction: returns to IDLE immediately. Any slave handshake in progress is abandoned and all valids drop asynchronously.

## Timing
- AW accepted at cycle T; DECODE at T+1; m_awvalid[tgt] asserted at T+2 at the earliest.
- Earliest s_bvalid: T+3, when the slave accepts AW+W at T+2 and responds combinationally in RESP at T+3. Registered-B slaves add one cycle.
- DECERR path: W accepted at T+2 at the earliest; s_bvalid=1 at T+3.
- Next AW accepted in the cycle after the B handshake, in IDLE.
- Valids are held stable until the handshake: once m_awvalid rises, aw_addr_q cannot change until aw_done.

## Test plan
- Slave 1 hit, ready slaves: AW 0x1000_0004 at T, W 0xDEAD_BEEF strb 0xF -> m_awvalid[1] at T+2, m_wdata=0xDEAD_BEEF, m_awvalid[0]=0 throughout, s_bresp=OKAY.
- Unmapped address (dec_slave_sel=0) -> W consumed, no m_*valid asserted, s_bvalid at T+3 with s_bresp=2'b11.
- Slave holds m_awready low 3 cycles, W accepted first -> w_done set, m_wvalid drops, AW completes later, single B returned.
- s_bready low 4 cycles in RESP -> s_bvalid held, m_bready[tgt]=0, s_awready stays 0; new AW accepted only after the B handshake.
- Slave returns m_bresp=2'b10 (SLVERR) -> s_bresp=2'b10 passed through unmodified.
- rst_n pulsed low in FWD with m_awvalid high -> all valids 0 immediately, state IDLE, next transaction completes normally.
